// File: rtl/bp_mem_cmd_delay_pkg.sv
// Shared helpers for the memory-command delay shim.
// Messages are opaque bit vectors; only count-width helpers live here.
package bp_mem_cmd_delay_pkg;

    // Bit width that can index x items; never returns 0.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_mem_cmd_delay_slot.sv
// One buffered command: payload, valid bit and saturating release countdown.
// Latency: countdown loads delay_p on load_i and is ripe delay_p cycles later.
// Backpressure: none internally; pop_i is only asserted by the top when sent.
module bp_mem_cmd_delay_slot
    import bp_mem_cmd_delay_pkg::*;
#(
    parameter int width_p = 8,
    parameter int delay_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               pop_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    output logic               ripe_o
);

    localparam int cnt_w_lp = safe_clog2(delay_p + 1);

    logic                v_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic [width_p-1:0]  data_r;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            v_r   <= 1'b0;
            cnt_r <= '0;
        end else if (load_i) begin
            v_r   <= 1'b1;
            cnt_r <= cnt_w_lp'(delay_p);
        end else begin
            if (pop_i)
                v_r <= 1'b0;
            if (v_r && (cnt_r != '0))
                cnt_r <= cnt_r - cnt_w_lp'(1);
        end
    end

    // Payload is qualified by v_r, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (load_i)
            data_r <= data_i;
    end

    assign data_o = data_r;
    assign v_o    = v_r;
    assign ripe_o = v_r && (cnt_r == '0);

endmodule

// File: rtl/bp_mem_cmd_delay.sv
// Memory-command delay/throttle shim; optional counters under BP_MEM_CMD_DELAY_STATS_EN.
// Latency: a command reaches mem_cmd_v_o no earlier than delay_p+1 cycles after accept.
// Backpressure: ready drops when full (no bypass); sends stall on ready_i or outstanding cap.
module bp_mem_cmd_delay
    import bp_mem_cmd_delay_pkg::*;
#(
    parameter int mem_msg_width_p   = 1,
    parameter int els_p             = 4,
    parameter int delay_p           = 8,
    parameter int max_outstanding_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [mem_msg_width_p-1:0] mem_cmd_i,
    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_ready_o,
    output logic [mem_msg_width_p-1:0] mem_cmd_o,
    output logic                       mem_cmd_v_o,
    input  logic                       mem_cmd_ready_i,
    input  logic [mem_msg_width_p-1:0] mem_resp_i,
    input  logic                       mem_resp_v_i,
    output logic                       mem_resp_yumi_o,
    output logic [mem_msg_width_p-1:0] mem_resp_o,
    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_yumi_i,
    output logic [safe_clog2(max_outstanding_p+1)-1:0] outstanding_o
`ifdef BP_MEM_CMD_DELAY_STATS_EN
    ,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                sent_cnt_o
`endif
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int occ_w_lp = safe_clog2(els_p + 1);
    localparam int out_w_lp = safe_clog2(max_outstanding_p + 1);

    logic [ptr_w_lp-1:0]        head_r, tail_r;
    logic [occ_w_lp-1:0]        occ_r;
    logic [out_w_lp-1:0]        out_r;
    logic [els_p-1:0]           slot_v, slot_ripe;
    logic [mem_msg_width_p-1:0] slot_data [els_p];
    logic                       accept, send, resp_hs, head_v, head_ripe, below_cap;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    for (genvar i = 0; i < els_p; i++) begin : g_slot
        bp_mem_cmd_delay_slot #(
            .width_p (mem_msg_width_p),
            .delay_p (delay_p)
        ) u_slot (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .load_i  (accept && (tail_r == ptr_w_lp'(i))),
            .pop_i   (send && (head_r == ptr_w_lp'(i))),
            .data_i  (mem_cmd_i),
            .data_o  (slot_data[i]),
            .v_o     (slot_v[i]),
            .ripe_o  (slot_ripe[i])
        );
    end

    assign mem_cmd_ready_o = reset_i && (occ_r != occ_w_lp'(els_p));
    assign accept          = mem_cmd_v_i && mem_cmd_ready_o;

    // Only the head may leave, so a ripe later entry waits behind an unripe head.
    assign head_v      = slot_v[head_r];
    assign head_ripe   = slot_ripe[head_r];
    assign below_cap   = out_r < out_w_lp'(max_outstanding_p);
    assign send        = reset_i && head_v && head_ripe && mem_cmd_ready_i && below_cap;
    assign mem_cmd_v_o = send;
    assign mem_cmd_o   = slot_data[head_r];

    assign mem_resp_o      = mem_resp_i;
    assign mem_resp_v_o    = mem_resp_v_i && reset_i;
    assign mem_resp_yumi_o = mem_resp_yumi_i;
    assign resp_hs         = mem_resp_v_o && mem_resp_yumi_i;
    assign outstanding_o   = out_r;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_r <= '0;
            tail_r <= '0;
            occ_r  <= '0;
            out_r  <= '0;
        end else begin
            if (accept)
                tail_r <= next_ptr(tail_r);
            if (send)
                head_r <= next_ptr(head_r);
            if (accept && !send)
                occ_r <= occ_r + occ_w_lp'(1);
            else if (!accept && send)
                occ_r <= occ_r - occ_w_lp'(1);
            if (send && !resp_hs)
                out_r <= out_r + out_w_lp'(1);
            else if (!send && resp_hs && (out_r != '0))
                out_r <= out_r - out_w_lp'(1);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_i && resp_hs && (out_r == '0))
            $error("bp_mem_cmd_delay: response with no command outstanding");
    end
`endif

`ifdef BP_MEM_CMD_DELAY_STATS_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_o <= '0;
            sent_cnt_o  <= '0;
        end else begin
            if (head_v && head_ripe && !send && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (send && (sent_cnt_o != '1))
                sent_cnt_o <= sent_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_mem_cmd_delay.sv
// Directed bench: a delay_p=8 instance (a_*) and a delay_p=0 instance (b_*).
// Cycle tables plus hand sequences for fill/drain, outstanding cap and reset.
module tb_bp_mem_cmd_delay;

    localparam int W = 16;

    typedef struct {
        logic         cmd_v;
        logic [W-1:0] cmd;
        logic         rdy_i;
        logic         resp;
        logic [W-1:0] resp_dat;
        logic         e_rdy;
        logic         e_v;
        logic [W-1:0] e_cmd;
        logic [1:0]   e_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [W-1:0] a_cmd = '0, a_cmd_o, a_resp = '0, a_resp_o;
    logic a_cmd_v = 0, a_ready_o, a_v_o, a_rdy_i = 0, a_resp_v = 0, a_yumi_o, a_resp_v_o, a_yumi = 0;
    logic [1:0] a_out;
    logic [W-1:0] b_cmd = '0, b_cmd_o, b_resp = '0, b_resp_o;
    logic b_cmd_v = 0, b_ready_o, b_v_o, b_rdy_i = 0, b_resp_v = 0, b_yumi_o, b_resp_v_o, b_yumi = 0;
    logic [1:0] b_out;
`ifdef BP_MEM_CMD_DELAY_STATS_EN
    logic [31:0] a_stall, a_sent, b_stall, b_sent;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_mem_cmd_delay #(.mem_msg_width_p(W), .els_p(4), .delay_p(8), .max_outstanding_p(2)) dut (
        .clk_i(clk), .reset_i(rst_n),
        .mem_cmd_i(a_cmd), .mem_cmd_v_i(a_cmd_v), .mem_cmd_ready_o(a_ready_o),
        .mem_cmd_o(a_cmd_o), .mem_cmd_v_o(a_v_o), .mem_cmd_ready_i(a_rdy_i),
        .mem_resp_i(a_resp), .mem_resp_v_i(a_resp_v), .mem_resp_yumi_o(a_yumi_o),
        .mem_resp_o(a_resp_o), .mem_resp_v_o(a_resp_v_o), .mem_resp_yumi_i(a_yumi),
        .outstanding_o(a_out)
`ifdef BP_MEM_CMD_DELAY_STATS_EN
        , .stall_cnt_o(a_stall), .sent_cnt_o(a_sent)
`endif
    );

    bp_mem_cmd_delay #(.mem_msg_width_p(W), .els_p(4), .delay_p(0), .max_outstanding_p(3)) dut0 (
        .clk_i(clk), .reset_i(rst_n),
        .mem_cmd_i(b_cmd), .mem_cmd_v_i(b_cmd_v), .mem_cmd_ready_o(b_ready_o),
        .mem_cmd_o(b_cmd_o), .mem_cmd_v_o(b_v_o), .mem_cmd_ready_i(b_rdy_i),
        .mem_resp_i(b_resp), .mem_resp_v_i(b_resp_v), .mem_resp_yumi_o(b_yumi_o),
        .mem_resp_o(b_resp_o), .mem_resp_v_o(b_resp_v_o), .mem_resp_yumi_i(b_yumi),
        .outstanding_o(b_out)
`ifdef BP_MEM_CMD_DELAY_STATS_EN
        , .stall_cnt_o(b_stall), .sent_cnt_o(b_sent)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic cv, input logic [W-1:0] c, input logic ri,
                                input logic rs, input logic [W-1:0] rd, input logic er,
                                input logic ev, input logic [W-1:0] ec, input logic [1:0] eo);
        vec_t r;
        r.cmd_v = cv; r.cmd = c; r.rdy_i = ri; r.resp = rs; r.resp_dat = rd;
        r.e_rdy = er; r.e_v = ev; r.e_cmd = ec; r.e_out = eo;
        return r;
    endfunction

    // One cycle: drive at edge+1, check at edge+4, advance to next edge+1.
    task automatic run_row(input int sel, input vec_t r, input string tag, input int idx);
        logic rdy, v, rv;
        logic [W-1:0] c, rd;
        logic [1:0] o;
        if (sel == 0) begin
            a_cmd_v = r.cmd_v; a_cmd = r.cmd; a_rdy_i = r.rdy_i;
            a_resp_v = r.resp; a_yumi = r.resp; a_resp = r.resp_dat;
        end else begin
            b_cmd_v = r.cmd_v; b_cmd = r.cmd; b_rdy_i = r.rdy_i;
            b_resp_v = r.resp; b_yumi = r.resp; b_resp = r.resp_dat;
        end
        #3;
        if (sel == 0) begin rdy = a_ready_o; v = a_v_o; c = a_cmd_o; o = a_out; rv = a_resp_v_o; rd = a_resp_o; end
        else begin rdy = b_ready_o; v = b_v_o; c = b_cmd_o; o = b_out; rv = b_resp_v_o; rd = b_resp_o; end
        chk($sformatf("%s[%0d].ready", tag, idx), rdy, r.e_rdy);
        chk($sformatf("%s[%0d].v", tag, idx), v, r.e_v);
        if (r.e_v) chk($sformatf("%s[%0d].cmd", tag, idx), c, r.e_cmd);
        chk($sformatf("%s[%0d].outstanding", tag, idx), o, r.e_out);
        chk($sformatf("%s[%0d].resp_v", tag, idx), rv, r.resp);
        if (r.resp) chk($sformatf("%s[%0d].resp", tag, idx), rd, r.resp_dat);
        @(posedge clk); #1;
    endtask

    task automatic a_idle();
        a_cmd_v = 0; a_rdy_i = 0; a_resp_v = 0; a_yumi = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t0[$];
        vec_t t3[$];
        logic [W-1:0] got[$];
        logic [W-1:0] d;
        int lat, nout, pop_cyc, nv;
        logic acc4, acc_ok, s, rs;

        // zero-delay stream on dut0 (max_outstanding 3)
        t0.push_back(mk(1, 16'hA001, 1, 0, 0,       1, 0, 0,       0));
        t0.push_back(mk(1, 16'hA002, 1, 0, 0,       1, 1, 16'hA001, 0));
        t0.push_back(mk(1, 16'hA003, 1, 1, 16'h5001, 1, 1, 16'hA002, 1));
        t0.push_back(mk(0, 0,        1, 1, 16'h5002, 1, 1, 16'hA003, 1));
        t0.push_back(mk(0, 0,        1, 1, 16'h5003, 1, 0, 0,       1));
        t0.push_back(mk(1, 16'hB001, 0, 0, 0,       1, 0, 0,       0));
        t0.push_back(mk(1, 16'hB002, 0, 0, 0,       1, 0, 0,       0));
        t0.push_back(mk(0, 0,        1, 0, 0,       1, 1, 16'hB001, 0));
        t0.push_back(mk(0, 0,        1, 0, 0,       1, 1, 16'hB002, 1));
        t0.push_back(mk(0, 0,        1, 0, 0,       1, 0, 0,       2));
        t0.push_back(mk(0, 0,        1, 1, 16'h5004, 1, 0, 0,       2));
        t0.push_back(mk(0, 0,        1, 1, 16'h5005, 1, 0, 0,       1));
        t0.push_back(mk(0, 0,        1, 0, 0,       1, 0, 0,       0));
        for (int i = 0; i < 4; i++)
            t0.push_back(mk(1, 16'hC001 + 16'(i), 0, 0, 0, 1, 0, 0, 0));
        t0.push_back(mk(1, 16'hC005, 0, 0, 0,       0, 0, 0,       0));
        t0.push_back(mk(0, 0,        1, 0, 0,       0, 1, 16'hC001, 0));
        t0.push_back(mk(0, 0,        0, 0, 0,       1, 0, 0,       1));
        t0.push_back(mk(0, 0,        1, 0, 0,       1, 1, 16'hC002, 1));
        t0.push_back(mk(0, 0,        1, 1, 16'h5006, 1, 1, 16'hC003, 2));
        t0.push_back(mk(0, 0,        1, 1, 16'h5007, 1, 1, 16'hC004, 2));
        t0.push_back(mk(0, 0,        1, 1, 16'h5008, 1, 0, 0,       2));
        t0.push_back(mk(0, 0,        1, 1, 16'h5009, 1, 0, 0,       1));
        t0.push_back(mk(0, 0,        1, 0, 0,       1, 0, 0,       0));

        // outstanding cap on dut (delay 8, max 2)
        for (int i = 0; i < 3; i++)
            t3.push_back(mk(1, 16'h3000 + 16'(i), 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            t3.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        t3.push_back(mk(0, 0, 1, 0, 0,       1, 1, 16'h3000, 0));
        t3.push_back(mk(0, 0, 1, 0, 0,       1, 1, 16'h3001, 1));
        t3.push_back(mk(0, 0, 1, 0, 0,       1, 0, 0,       2));
        t3.push_back(mk(0, 0, 1, 1, 16'h6001, 1, 0, 0,       2));
        t3.push_back(mk(0, 0, 1, 1, 16'h6002, 1, 1, 16'h3002, 1));
        t3.push_back(mk(0, 0, 1, 1, 16'h6003, 1, 0, 0,       1));
        t3.push_back(mk(0, 0, 0, 0, 0,       1, 0, 0,       0));

        // reset state
        @(posedge clk); #1;
        a_rdy_i = 1; a_resp_v = 1;
        #3;
        chk("reset.ready", a_ready_o, 0);
        chk("reset.v", a_v_o, 0);
        chk("reset.outstanding", a_out, 0);
        chk("reset.resp_v_gated", a_resp_v_o, 0);
        a_idle();
        @(posedge clk); #1;
        rst_n = 1;
        #3;
        chk("post_reset.ready", a_ready_o, 1);
        @(posedge clk); #1;

        for (int i = 0; i < t0.size(); i++) run_row(1, t0[i], "zero_delay", i);
        b_cmd_v = 0; b_rdy_i = 0; b_resp_v = 0; b_yumi = 0;

        // single command latency
        a_rdy_i = 1; a_cmd_v = 1; a_cmd = 16'h1234;
        #3;
        chk("t1.accept_ready", a_ready_o, 1);
        chk("t1.v_at_accept", a_v_o, 0);
        @(posedge clk); #1;
        a_cmd_v = 0;
        lat = 0; d = '0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            #3;
            if (a_v_o) begin lat = n; d = a_cmd_o; end
            @(posedge clk); #1;
        end
        chk("t1.latency", lat, 9);
        chk("t1.payload", d, 16'h1234);
        #3;
        chk("t1.outstanding", a_out, 1);
        @(posedge clk); #1;
        a_resp_v = 1; a_yumi = 1; a_resp = 16'hBEEF;
        #3;
        chk("t1.resp_v", a_resp_v_o, 1);
        chk("t1.resp", a_resp_o, 16'hBEEF);
        chk("t1.resp_yumi", a_yumi_o, 1);
        @(posedge clk); #1;
        a_idle();
        #3;
        chk("t1.outstanding_after_resp", a_out, 0);
        @(posedge clk); #1;

        // fill to full, then drain in order
        for (int i = 0; i < 4; i++) begin
            a_cmd_v = 1; a_cmd = 16'h0200 + 16'(i);
            #3;
            chk($sformatf("t2.ready_fill%0d", i), a_ready_o, 1);
            @(posedge clk); #1;
        end
        a_cmd = 16'h0204;
        #3;
        chk("t2.ready_full", a_ready_o, 0);
        @(posedge clk); #1;
        nout = 0; acc4 = 0; acc_ok = 0; pop_cyc = -1;
        for (int n = 0; n < 60 && !(got.size() == 5 && nout == 0); n++) begin
            a_rdy_i = 1; a_cmd_v = !acc4;
            rs = (nout > 0); a_resp_v = rs; a_yumi = rs;
            #3;
            s = a_v_o;
            if (s) begin
                got.push_back(a_cmd_o);
                if (pop_cyc < 0) begin
                    pop_cyc = cyc;
                    chk("t2.no_bypass_ready", a_ready_o, 0);
                end
            end
            if (!acc4 && a_ready_o) begin
                acc4 = 1;
                acc_ok = (pop_cyc >= 0) && (cyc == pop_cyc + 1);
            end
            @(posedge clk); #1;
            nout = nout + int'(s) - int'(rs);
        end
        a_idle();
        chk("t2.count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2.order%0d", i), (i < got.size()) ? got[i] : 16'hFFFF, 16'h0200 + 16'(i));
        chk("t2.fifth_after_pop", acc_ok, 1);
        #3;
        chk("t2.outstanding_drained", a_out, 0);
        @(posedge clk); #1;

        for (int i = 0; i < t3.size(); i++) run_row(0, t3[i], "cap", i);
        a_idle();

        // reset mid-operation: 3 buffered, 1 outstanding
        for (int i = 0; i < 4; i++) begin
            a_cmd_v = 1; a_cmd = 16'h0500 + 16'(i);
            @(posedge clk); #1;
        end
        a_cmd_v = 0;
        repeat (9) begin @(posedge clk); #1; end
        a_rdy_i = 1;
        #3;
        chk("t5.send_one", a_v_o, 1);
        @(posedge clk); #1;
        a_rdy_i = 0;
        #3;
        chk("t5.outstanding_before", a_out, 1);
        @(posedge clk); #1;
        rst_n = 0; a_rdy_i = 1; a_resp_v = 1;
        #2;
        chk("t5.ready_in_reset", a_ready_o, 0);
        chk("t5.v_in_reset", a_v_o, 0);
        chk("t5.outstanding_in_reset", a_out, 0);
        chk("t5.resp_v_in_reset", a_resp_v_o, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1; a_resp_v = 0;
        #2;
        chk("t5.ready_after", a_ready_o, 1);
        chk("t5.outstanding_after", a_out, 0);
        @(posedge clk); #1;
        nv = 0;
        repeat (15) begin
            #3;
            if (a_v_o) nv++;
            @(posedge clk); #1;
        end
        chk("t5.no_stale_cmd", nv, 0);
        a_idle();

`ifdef BP_MEM_CMD_DELAY_STATS_EN
        a_cmd_v = 1; a_cmd = 16'h0600;
        @(posedge clk); #1;
        a_cmd_v = 0;
        repeat (13) begin @(posedge clk); #1; end
        a_rdy_i = 1;
        #3;
        chk("t6.release", a_v_o, 1);
        @(posedge clk); #1;
        a_rdy_i = 0;
        #3;
        chk("t6.stall_cnt", a_stall, 5);
        chk("t6.sent_cnt", a_sent, 1);
        @(posedge clk); #1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
